// File: rtl/tx_serial_uart_n.sv
// Asynchronous-serial transmitter with a one-entry holding buffer.
// Frames each character as start bit, DATA_BITS data bits (LSB first),
// an optional parity bit and STOP_BITS stop bits, CLKS_PER_BIT clocks per bit.
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   partida      request: offer dados this cycle
//   dados        character to transmit
//   pronto       holding buffer empty; partida is accepted this cycle
//   saida_serial serial line, idles high
//   ocupado      frame in progress (start through last stop bit)
//   fim          one-cycle pulse on last cycle of last stop bit
//   erro         one-cycle pulse on partida while pronto=0 (overrun)
module tx_serial_uart_n #(
   parameter int unsigned DATA_BITS    = 7,
   parameter int unsigned PARITY       = 1,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 partida,
   input  logic [DATA_BITS-1:0] dados,
   output logic                 pronto,
   output logic                 saida_serial,
   output logic                 ocupado,
   output logic                 fim,
   output logic                 erro
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = 4;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      REPOUSO  = 3'd0,
      INICIO   = 3'd1,
      DADOS    = 3'd2,
      PARIDADE = 3'd3,
      PARADA   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [DATA_BITS-1:0] buf_q, buf_d;
   logic                 pronto_q, pronto_d;
   logic                 line_q, line_d;
   logic                 ocup_q, ocup_d;
   logic                 fim_q, fim_d;
   logic                 erro_q, erro_d;

   logic                 baud_tc;
   logic                 load;
   logic                 buf_par;

   // State register and all datapath flops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= REPOUSO;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         buf_q    <= '0;
         pronto_q <= 1'b1;
         line_q   <= 1'b1;
         ocup_q   <= 1'b0;
         fim_q    <= 1'b0;
         erro_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         buf_q    <= buf_d;
         pronto_q <= pronto_d;
         line_q   <= line_d;
         ocup_q   <= ocup_d;
         fim_q    <= fim_d;
         erro_q   <= erro_d;
      end
   end

   // Parity of the buffered character, taken when it moves to the shifter.
   assign buf_par = (PARITY == 2) ? (^buf_q) : (~^buf_q);

   // Next-state, counters, shifter and holding buffer.
   always_comb begin
      state_d  = state_q;
      baud_tc  = (baud_q == BAUD_LAST);
      baud_d   = baud_tc ? '0 : baud_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      buf_d    = buf_q;
      pronto_d = pronto_q;
      load     = 1'b0;

      unique case (state_q)
         REPOUSO: begin
            baud_d = '0;
            load   = !pronto_q;
         end
         INICIO: begin
            if (baud_tc) begin
               state_d = DADOS;
               bit_d   = '0;
            end
         end
         DADOS: begin
            if (baud_tc) begin
               if (bit_q == DATA_LAST) begin
                  state_d = (PARITY != 0) ? PARIDADE : PARADA;
                  bit_d   = '0;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         PARIDADE: begin
            if (baud_tc) begin
               state_d = PARADA;
               bit_d   = '0;
            end
         end
         PARADA: begin
            if (baud_tc) begin
               if (bit_q == STOP_LAST) begin
                  // A full buffer chains straight into the next start bit.
                  if (!pronto_q) load = 1'b1;
                  else           state_d = REPOUSO;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = REPOUSO;
      endcase

      if (load) begin
         state_d  = INICIO;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = buf_q;
         par_d    = buf_par;
         pronto_d = 1'b1;
      end

      // load needs pronto_q=0, acceptance needs pronto_q=1: never both.
      if (partida && pronto_q) begin
         buf_d    = dados;
         pronto_d = 1'b0;
      end
   end

   // Registered outputs, derived from the next state so they line up with it.
   always_comb begin
      line_d = 1'b1;
      unique case (state_d)
         INICIO:   line_d = 1'b0;
         DADOS:    line_d = shift_d[0];
         PARIDADE: line_d = par_d;
         default:  line_d = 1'b1;
      endcase
      ocup_d = (state_d != REPOUSO);
      fim_d  = (state_d == PARADA) && (bit_d == STOP_LAST) && (baud_d == BAUD_LAST);
      erro_d = partida && !pronto_q;
   end

   assign pronto       = pronto_q;
   assign saida_serial = line_q;
   assign ocupado      = ocup_q;
   assign fim          = fim_q;
   assign erro         = erro_q;

endmodule
